// File: rtl/rhythm_pkg.sv
// rhythm_pkg: shared types for the rhythm-game lane logic.
// Grade codes, lane FSM states, control keycodes, score helper.
package rhythm_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    GOOD    = 2'd1,
    PERFECT = 2'd2
  } grade_t;

  typedef enum logic [1:0] {
    LANE_HALTED = 2'd0,
    LANE_WAIT   = 2'd1,
    LANE_FALL   = 2'd2,
    LANE_DONE   = 2'd3
  } lane_state_t;

  localparam logic [7:0] KEY_SPACE   = 8'h2C;
  localparam logic [7:0] KEY_RESTART = 8'h01;

  function automatic logic [7:0] sat_add8(
    input logic [7:0] a,
    input logic [1:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/arrow_sprite_rom.sv
// arrow_sprite_rom: 40x40 right-pointing arrow mask, bit = row*40+col.
// Ports: note_visible (in) gates the mask; arrow (out, 1600) is zero when hidden.
module arrow_sprite_rom (
  input  logic          note_visible,
  output logic [1599:0] arrow
);

  // Shaft: rows 15..24, cols 0..19. Head: triangle from col 20
  // (full height) narrowing to rows 19..20 at col 39.
  function automatic logic [1599:0] arrow_mask();
    logic [1599:0] m;
    int dr;
    m = '0;
    for (int r = 0; r < 40; r++) begin
      dr = (r < 20) ? 19 - r : r - 20;
      for (int c = 0; c < 40; c++) begin
        m[r*40+c] = (r >= 15 && r <= 24 && c < 20)
                 || (c >= 20 && dr <= 39 - c);
      end
    end
    return m;
  endfunction

  localparam logic [1599:0] MASK = arrow_mask();

  assign arrow = note_visible ? MASK : '0;

endmodule

// File: rtl/note_lane_dropper.sv
// note_lane_dropper: one rhythm-game lane playing a fixed note schedule.
// Ports: frame_clk, Reset (sync, active-high), keycode, keycode_second;
//   outputs dropX, dropY, note_visible, arrow, hit_pulse, miss_pulse,
//   hit_grade, lane_score, done.
// Build option: DROPPER_GRADE_EN enables PERFECT grading (+2 points).
module note_lane_dropper
  import rhythm_pkg::*;
#(
  parameter int X_POS      = 500,
  parameter int Y_START    = 100,
  parameter int Y_MAX      = 400,
  parameter int NOTE_H     = 40,
  parameter int SPEED      = 1,
  parameter int HIT_LO     = 340,
  parameter int PERFECT_LO = 370,
  parameter logic [7:0] LANE_KEY = 8'h4F,
  parameter int NUM_NOTES  = 4,
  parameter logic [12*NUM_NOTES-1:0] SPAWN_FRAMES =
    {12'd2740, 12'd2800, 12'd2900, 12'd3000}
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic [7:0]    keycode,
  input  logic [7:0]    keycode_second,
  output logic [9:0]    dropX,
  output logic [9:0]    dropY,
  output logic          note_visible,
  output logic [1599:0] arrow,
  output logic          hit_pulse,
  output logic          miss_pulse,
  output grade_t        hit_grade,
  output logic [7:0]    lane_score,
  output logic          done
);

`ifdef DROPPER_GRADE_EN
  localparam bit GRADE_EN = 1'b1;
`else
  localparam bit GRADE_EN = 1'b0;
`endif

  lane_state_t state;
  logic [11:0] frame_cnt;
  logic [4:0]  idx;
  logic        key_prev;

  logic        key_now;
  logic        press;
  logic        restart;
  logic [10:0] bottom;
  logic        in_miss;
  logic        in_hit;
  logic        perfect;
  logic        last_note;
  logic [11:0] spawn_at;
  logic [12*NUM_NOTES-1:0] sched;

  assign key_now = (keycode == LANE_KEY)
                 | (keycode_second == LANE_KEY);
  assign press   = key_now & ~key_prev;
  assign restart = (keycode == KEY_RESTART);

  // 11-bit so the bottom edge never wraps near the screen limit.
  assign bottom  = {1'b0, dropY} + 11'(NOTE_H);
  assign in_miss = bottom >= 11'(Y_MAX);
  assign in_hit  = press && (bottom >= 11'(HIT_LO));
  assign perfect = GRADE_EN && (bottom >= 11'(PERFECT_LO));

  // Note 0 sits in the MSBs; shift the current note to the top.
  assign sched    = SPAWN_FRAMES << (12 * int'(idx));
  assign spawn_at = sched[12*NUM_NOTES-1 -: 12];
  assign last_note = (idx == 5'(NUM_NOTES - 1));

  assign dropX = 10'(X_POS);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state        <= LANE_HALTED;
      frame_cnt    <= '0;
      idx          <= '0;
      key_prev     <= 1'b0;
      dropY        <= 10'(Y_START);
      note_visible <= 1'b0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      hit_grade    <= NONE;
      lane_score   <= '0;
      done         <= 1'b0;
    end else begin
      key_prev   <= key_now;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;

      if ((state == LANE_WAIT || state == LANE_FALL)
          && frame_cnt != 12'hFFF)
        frame_cnt <= frame_cnt + 12'd1;

      // Restart aborts any note silently: no pulse.
      if (state != LANE_HALTED && restart) begin
        state        <= LANE_HALTED;
        frame_cnt    <= '0;
        idx          <= '0;
        dropY        <= 10'(Y_START);
        note_visible <= 1'b0;
        hit_grade    <= NONE;
        lane_score   <= '0;
        done         <= 1'b0;
      end else begin
        unique case (state)
          LANE_HALTED: begin
            if (keycode == KEY_SPACE)
              state <= LANE_WAIT;
          end
          LANE_WAIT: begin
            if (frame_cnt >= spawn_at) begin
              state        <= LANE_FALL;
              dropY        <= 10'(Y_START);
              note_visible <= 1'b1;
            end
          end
          LANE_FALL: begin
            if (in_miss || in_hit) begin
              note_visible <= 1'b0;
              dropY        <= 10'(Y_START);
              idx          <= idx + 5'd1;
              state        <= last_note ? LANE_DONE : LANE_WAIT;
              done         <= last_note;
              if (in_miss) begin
                miss_pulse <= 1'b1;
              end else begin
                hit_pulse  <= 1'b1;
                hit_grade  <= perfect ? PERFECT : GOOD;
                lane_score <= sat_add8(lane_score,
                                       perfect ? 2'd2 : 2'd1);
              end
            end else begin
              dropY <= dropY + 10'(SPEED);
            end
          end
          LANE_DONE: ;
          default: state <= LANE_HALTED;
        endcase
      end
    end
  end

  arrow_sprite_rom u_rom (
    .note_visible(note_visible),
    .arrow       (arrow)
  );

endmodule

// File: tb/tb_note_lane_dropper.sv
// tb_note_lane_dropper: directed bench for note_lane_dropper.
// Frame-level reference model plus hand-computed checkpoints.
module tb_note_lane_dropper;

  localparam int X_POS   = 500;
  localparam int Y_START = 100;
  localparam int Y_MAX   = 400;
  localparam int NOTE_H  = 40;
  localparam int SPEED   = 1;
  localparam int HIT_LO  = 340;
  localparam int PERF_LO = 370;
  localparam int NN      = 3;
`ifdef DROPPER_GRADE_EN
  localparam bit GEN = 1'b1;
`else
  localparam bit GEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          Reset;
  logic [7:0]    keycode;
  logic [7:0]    keycode_second;
  logic [9:0]    dropX;
  logic [9:0]    dropY;
  logic          note_visible;
  logic [1599:0] arrow;
  logic          hit_pulse;
  logic          miss_pulse;
  logic [1:0]    hit_grade;
  logic [7:0]    lane_score;
  logic          done;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  note_lane_dropper #(
    .NUM_NOTES   (NN),
    .SPAWN_FRAMES({12'd10, 12'd12, 12'd14})
  ) dut (
    .frame_clk     (clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .keycode_second(keycode_second),
    .dropX         (dropX),
    .dropY         (dropY),
    .note_visible  (note_visible),
    .arrow         (arrow),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse),
    .hit_grade     (hit_grade),
    .lane_score    (lane_score),
    .done          (done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 waiting, 2 falling, 3 finished.
  int spawn[NN] = '{10, 12, 14};
  int m_mode, m_cnt, m_idx, m_y, m_grade, m_score;
  bit m_vis, m_hit, m_miss, m_done, m_kprev;

  task automatic m_clear();
    m_mode = 0; m_cnt = 0; m_idx = 0; m_y = Y_START;
    m_vis = 0; m_grade = 0; m_score = 0; m_done = 0;
  endtask

  task automatic m_resolve();
    m_vis = 0;
    m_y = Y_START;
    m_idx++;
    if (m_idx == NN) begin
      m_mode = 3;
      m_done = 1;
    end else begin
      m_mode = 1;
    end
  endtask

  always @(posedge clk) begin
    bit kn, pr;
    int bot, old_cnt, pts;
    kn = (keycode == 8'h4F) || (keycode_second == 8'h4F);
    m_hit = 0;
    m_miss = 0;
    if (Reset) begin
      m_clear();
      m_kprev = 0;
    end else begin
      pr = kn && !m_kprev;
      m_kprev = kn;
      old_cnt = m_cnt;
      if (m_mode == 1 || m_mode == 2)
        m_cnt = (m_cnt < 4095) ? m_cnt + 1 : 4095;
      if (m_mode != 0 && keycode == 8'h01) begin
        m_clear();
      end else if (m_mode == 0) begin
        if (keycode == 8'h2C) m_mode = 1;
      end else if (m_mode == 1) begin
        if (old_cnt >= spawn[m_idx]) begin
          m_mode = 2; m_y = Y_START; m_vis = 1;
        end
      end else if (m_mode == 2) begin
        bot = m_y + NOTE_H;
        if (bot >= Y_MAX) begin
          m_miss = 1;
          m_resolve();
        end else if (pr && bot >= HIT_LO) begin
          m_hit = 1;
          pts = (GEN && bot >= PERF_LO) ? 2 : 1;
          m_grade = pts;
          m_score = (m_score + pts > 255) ? 255 : m_score + pts;
          m_resolve();
        end else begin
          m_y = m_y + SPEED;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("dropX", int'(dropX), X_POS);
      chk("dropY", int'(dropY), m_y);
      chk("visible", int'(note_visible), int'(m_vis));
      chk("hit_pulse", int'(hit_pulse), int'(m_hit));
      chk("miss_pulse", int'(miss_pulse), int'(m_miss));
      chk("hit_grade", int'(hit_grade), m_grade);
      chk("lane_score", int'(lane_score), m_score);
      chk("done", int'(done), int'(m_done));
      chk("arrow_pop", int'($countones(arrow)), m_vis ? 620 : 0);
    end
  end

  task automatic wait_y(input int t);
    int n = 0;
    while (!(note_visible && int'(dropY) == t) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) chk("wait_y_timeout", int'(dropY), t);
  endtask

  initial begin
    int n, last_y;
    Reset = 1'b1;
    keycode = 8'h00;
    keycode_second = 8'h00;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_dropY", int'(dropY), 100);
    chk("rst_dropX", int'(dropX), 500);
    chk("rst_vis", int'(note_visible), 0);
    chk("rst_score", int'(lane_score), 0);
    chk("rst_grade", int'(hit_grade), 0);
    chk("rst_done", int'(done), 0);
    Reset = 1'b0;

    keycode = 8'h2C;
    @(negedge clk);
    keycode = 8'h00;
    repeat (10) @(negedge clk);
    chk("spawn_f10_vis", int'(note_visible), 0);
    @(negedge clk);
    chk("spawn_f11_vis", int'(note_visible), 1);
    chk("spawn_y0", int'(dropY), 100);
    chk("model_y0", m_y, 100);
    chk("arrow_tip", int'(arrow[19*40+39]), 1);
    chk("arrow_corner", int'(arrow[0]), 0);
    chk("arrow_shaft", int'(arrow[15*40]), 1);
    chk("arrow_above", int'(arrow[14*40]), 0);
    @(negedge clk);
    chk("spawn_y1", int'(dropY), 101);

    keycode = 8'h4F;
    n = 0;
    last_y = 0;
    while (!miss_pulse && n < 600) begin
      if (note_visible) last_y = int'(dropY);
      @(negedge clk);
      n++;
    end
    chk("miss_seen", int'(miss_pulse), 1);
    chk("miss_y", last_y, 360);
    chk("hold_score", int'(lane_score), 0);
    keycode = 8'h00;

    wait_y(295);
    keycode = 8'h4F;
    @(negedge clk);
    keycode = 8'h00;
    chk("early_vis", int'(note_visible), 1);
    chk("early_y", int'(dropY), 296);
    chk("early_hit", int'(hit_pulse), 0);

    wait_y(335);
    keycode = 8'h4F;
    @(negedge clk);
    keycode = 8'h00;
    chk("hit1_pulse", int'(hit_pulse), 1);
    chk("hit1_grade", int'(hit_grade), GEN ? 2 : 1);
    chk("hit1_score", int'(lane_score), GEN ? 2 : 1);
    chk("hit1_vis", int'(note_visible), 0);

    wait_y(305);
    keycode_second = 8'h4F;
    @(negedge clk);
    keycode_second = 8'h00;
    chk("hit2_pulse", int'(hit_pulse), 1);
    chk("hit2_grade", int'(hit_grade), 1);
    chk("hit2_score", int'(lane_score), GEN ? 3 : 2);
    chk("done_set", int'(done), 1);
    @(negedge clk);
    chk("pulse_width", int'(hit_pulse), 0);
    chk("done_hold", int'(done), 1);

    keycode = 8'h01;
    @(negedge clk);
    keycode = 8'h00;
    chk("halt_done", int'(done), 0);
    chk("halt_score", int'(lane_score), 0);
    chk("halt_grade", int'(hit_grade), 0);
    chk("halt_y", int'(dropY), 100);

    keycode = 8'h2C;
    @(negedge clk);
    keycode = 8'h00;
    wait_y(103);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    chk("rst_mid_vis", int'(note_visible), 0);
    chk("rst_mid_y", int'(dropY), 100);
    chk("rst_mid_miss", int'(miss_pulse), 0);
    chk("rst_mid_score", int'(lane_score), 0);

    keycode = 8'h2C;
    @(negedge clk);
    keycode = 8'h00;
    wait_y(110);
    keycode = 8'h01;
    @(negedge clk);
    keycode = 8'h00;
    chk("abort_vis", int'(note_visible), 0);
    chk("abort_miss", int'(miss_pulse), 0);
    chk("abort_y", int'(dropY), 100);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
